mac_stream_acc: RTL and testbench
=================================

Name: mac_stream_acc

Overview:
Streaming fixed-point multiply-accumulate stage that directly consumes the element stream produced by the RAM-fed input multiplexer.
- Accepts one signed operand pair per cycle under valid/ready.
- Accumulates DEPTH products into one dot product.
- Rescales, rounds and saturates the sum back to WIDTH bits.
- Presents the result to the downstream writeback stage under valid/ready.

Parameters:
- WIDTH, 16: signed operand and result width.
- FRAC, 8: fractional bits of the Q format (Q8.8 by default).
- DEPTH, 4: terms per dot product (matches the 4-way input stream); must be ≥ 1.
- ACC_W, 40: accumulator width; must be ≥ 2*WIDTH + clog2(DEPTH).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operand pair valid.
- in_ready, output, 1: stage can accept a pair.
- in_a, input, WIDTH: signed operand A, Q(WIDTH-FRAC).FRAC.
- in_b, input, WIDTH: signed operand B, same format.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: signed rounded/saturated dot product.
- out_sat, output, 1: result was clipped; qualified by out_valid.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n low.
- Reset values: in_ready=0 while rst_n low, 1 on the first cycle after release; out_valid=0, out_data=0, out_sat=0, accumulator=0, term count=0, state=ACCUM.
- Input handshake:
  - A pair is accepted when in_valid && in_ready at a clock edge.
  - in_a and in_b are ignored otherwise.
- Stage 1: the full-precision product (2*WIDTH signed) is registered one cycle after acceptance.
- Stage 2: the product is sign-extended to ACC_W and added to the accumulator on the following cycle.
- FSM ACCUM:
  - in_ready=1.
  - Term counter increments on each accept.
  - On accepting term DEPTH-1: counter wraps to 0, in_ready drops next cycle, go to DRAIN.
- FSM DRAIN:
  - in_ready=0.
  - Waits one cycle for the last product to reach the accumulator.
  - Then loads out_data/out_sat from the rescaler, sets out_valid=1, goes to HOLD.
- FSM HOLD:
  - in_ready=0.
  - out_valid, out_data and out_sat stay stable until out_ready=1.
  - On out_valid && out_ready: out_valid=0, accumulator cleared, state returns to ACCUM, in_ready=1 the next cycle.
- Latency: last term accepted at edge t → out_valid=1 after edge t+2. Back-to-back throughput is DEPTH+3 cycles per result with out_ready tied high.
- Rescale:
  - Arithmetic right shift of the accumulator by FRAC, with optional rounding (see Optional Feature).
  - Then saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - out_sat=1 iff clipping occurred.
- The accumulator never wraps given the ACC_W constraint.
- DEPTH=1: ACCUM → DRAIN after every accept.
- in_valid gaps inside a dot product are allowed; the counter and accumulator simply hold.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-dot-product or mid-HOLD discards the partial sum and any pending result; no output is produced for it.

Optional Feature:
- Macro: MAC_ROUND_EN.
- Defined: round-half-up, i.e. add 2^(FRAC-1) to the accumulator before the shift, then saturate; rounding can itself cause saturation.
- Undefined: plain truncation (floor via arithmetic shift), with no adder in the rescale path.

Decomposition:
- Package mac_pkg holds:
  - state enum {ACCUM, DRAIN, HOLD};
  - default WIDTH/FRAC/DEPTH constants;
  - ACC_W derivation;
  - signed min/max constants.
- Sub-module mac_sat_round: combinational ACC_W→WIDTH shift/round/saturate producing data and sat flag; reused by other MAC variants.

Test Plan:
- Basic dot product, Q8.8, out_ready=1:
  - Stimulus: a={0x0100,0x0200,0x0080,0xFF00}, b={0x0100,0x0100,0x0200,0x0100}.
  - Expect out_data=0x0300, out_sat=0, out_valid exactly 2 cycles after the 4th accept, for one cycle.
- Saturation:
  - All four pairs a=b=0x7FFF → out_data=0x7FFF, out_sat=1.
  - All four pairs a=0x8000, b=0x7FFF → out_data=0x8000, out_sat=1.
- Rounding:
  - Stimulus: pairs {0x0001×0x0080, then 3×(0,0)}.
  - With MAC_ROUND_EN: out_data=0x0001. Without: 0x0000.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Expect out_data stable, in_ready=0 throughout, and no input accepted despite in_valid=1.
  - After the handshake, in_ready=1 the next cycle and the next result is correct.
- Input gaps:
  - Toggle in_valid 1,0,0,1,0,1,1 carrying terms of example 1.
  - Expect the identical 0x0300 result and exactly one out_valid.
- Reset mid-operation:
  - Assert rst_n low asynchronously after 2 of 4 terms.
  - Expect outputs zero immediately.
  - After release, a fresh 4-term sequence from example 1 yields 0x0300, uncontaminated by the partial sum.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and defaults for the streaming MAC stages.
// State encoding, Q-format defaults and accumulator sizing.
package mac_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int FRAC_DEF  = 8;
    localparam int DEPTH_DEF = 4;

    // Smallest accumulator that cannot wrap over DEPTH full-scale products.
    function automatic int acc_w_min(input int width, input int depth);
        return 2 * width + $clog2(depth);
    endfunction

    localparam int ACC_W_MIN_DEF = acc_w_min(WIDTH_DEF, DEPTH_DEF);
    localparam int ACC_W_DEF     = 40;

    localparam logic signed [WIDTH_DEF-1:0] SMAX_DEF = 16'sh7FFF;
    localparam logic signed [WIDTH_DEF-1:0] SMIN_DEF = 16'sh8000;

endpackage

// File: rtl/mac_sat_round.sv
// Combinational rescale: arithmetic shift by FRAC, then saturate.
// MAC_ROUND_EN adds round-half-up ahead of the shift.
module mac_sat_round #(
    parameter int ACC_W = 40,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [WIDTH-1:0] data_o,
    output logic             sat_o
);

    localparam int PADW = ACC_W + 2 - WIDTH;

    localparam logic signed [ACC_W:0] SMAX =
        {{PADW{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SMIN =
        {{PADW{1'b1}}, {(WIDTH-1){1'b0}}};

    // One guard bit so the rounding add cannot overflow.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] shf;

`ifdef MAC_ROUND_EN
    localparam logic signed [ACC_W:0] HALF =
        ((ACC_W+1)'(1) << FRAC) >> 1;
    assign ext = $signed({acc_i[ACC_W-1], acc_i}) + HALF;
`else
    assign ext = $signed({acc_i[ACC_W-1], acc_i});
`endif

    assign shf = ext >>> FRAC;

    // Clip the shifted value into the signed WIDTH range.
    always_comb begin
        sat_o  = 1'b0;
        data_o = shf[WIDTH-1:0];
        if (shf > SMAX) begin
            sat_o  = 1'b1;
            data_o = SMAX[WIDTH-1:0];
        end else if (shf < SMIN) begin
            sat_o  = 1'b1;
            data_o = SMIN[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mac_stream_acc.sv
// Streaming dot-product MAC: multiply, accumulate DEPTH terms, rescale.
// Rounding in the rescaler is enabled by defining MAC_ROUND_EN.
module mac_stream_acc
    import mac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [2*WIDTH-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;

    logic [WIDTH-1:0] rs_data;
    logic             rs_sat;
    logic             accept;
    logic             last_term;
    logic             release_out;
    logic             load;
    logic             clear;

    assign accept      = in_valid && in_ready_q;
    assign last_term   = accept && (cnt_q == LAST);
    assign release_out = out_valid_q && out_ready;

    mac_sat_round #(
        .ACC_W (ACC_W),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_sat_round (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // State register plus all datapath and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    // Next state: DRAIN waits until no product is still in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (last_term) state_d = DRAIN;
            DRAIN:   if (!prod_vld_q) state_d = HOLD;
            HOLD:    if (release_out) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // FSM outputs: result load, accumulator clear, registered ready.
    always_comb begin
        load       = (state_q == DRAIN) && !prod_vld_q;
        clear      = (state_q == HOLD) && release_out;
        in_ready_d = (state_d == ACCUM);
    end

    // Two-stage datapath: product register, then accumulate.
    always_comb begin
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_vld_d = accept;
        acc_d      = acc_q;
        if (accept) begin
            cnt_d  = last_term ? '0 : cnt_q + 1'b1;
            prod_d = $signed(in_a) * $signed(in_b);
        end
        if (clear) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
    end

    // Result register holds until the downstream handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = rs_data;
            out_sat_d   = rs_sat;
        end else if (release_out) begin
            out_valid_d = 1'b0;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_stream_acc.sv
// Scoreboard bench for mac_stream_acc (Q8.8, DEPTH 4).
// Reference dot product computed with plain integer arithmetic.
module tb_mac_stream_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -100;
    int rdy_mode = 0;

    logic [16:0] expq[$];
    logic [15:0] ta[$];
    logic [15:0] tbv[$];

    mac_stream_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Q16.16 sum -> Q8.8 with floor or round-half-up, then clip.
    function automatic logic [16:0] model(input longint s);
        longint v;
`ifdef MAC_ROUND_EN
        v = (s + 128) >>> 8;
`else
        v = s >>> 8;
`endif
        if (v > 32767) return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic send(input logic [15:0] a,
                        input logic [15:0] b,
                        input int gap);
        int t;
        bit done;
        longint s;
        t = 0;
        done = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!done && t < 200) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept");
        end else begin
            ta.push_back(a);
            tbv.push_back(b);
            if (ta.size() == 4) begin
                s = 0;
                foreach (ta[i])
                    s += longint'($signed(ta[i])) *
                         longint'($signed(tbv[i]));
                expq.push_back(model(s));
                last_acc = cyc;
                ta.delete();
                tbv.delete();
            end
        end
    endtask

    task automatic send_basic(input int g0, input int g1,
                              input int g2, input int g3);
        send(16'h0100, 16'h0100, g0);
        send(16'h0200, 16'h0100, g1);
        send(16'h0080, 16'h0200, g2);
        send(16'hFF00, 16'h0100, g3);
    endtask

    task automatic send_same(input logic [15:0] a,
                             input logic [15:0] b);
        repeat (4) send(a, b, 0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0",
                     expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshake checks, stability, latency, scoreboard.
    logic        prev_v = 1'b0;
    logic [16:0] prev_d = '0;
    logic        want_rdy = 1'b0;
    logic [16:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            want_rdy = 1'b0;
        end else begin
            if (want_rdy) check("ready_after_hs", 32'(in_ready), 1);
            want_rdy = 1'b0;
            if (out_valid) begin
                check("in_ready_low_hold", 32'(in_ready), 0);
                if (!prev_v)
                    check("latency", cyc, last_acc + 2);
                else
                    check("hold_stable", {out_sat, out_data}, prev_d);
                prev_v = 1'b1;
                prev_d = {out_sat, out_data};
                if (out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%h required=none",
                                 {out_sat, out_data});
                    end else begin
                        e = expq.pop_front();
                        check("result", {out_sat, out_data}, e);
                    end
                    want_rdy = 1'b1;
                    prev_v = 1'b0;
                end
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] ra;
    logic [15:0] rb;

    initial begin
        // Reset state.
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(in_ready), 1);

        // Basic, saturation both ways, rounding.
        send_basic(0, 0, 0, 0);
        wait_idle();
        send_same(16'h7FFF, 16'h7FFF);
        wait_idle();
        send_same(16'h8000, 16'h7FFF);
        wait_idle();
        send(16'h0001, 16'h0080, 0);
        send(16'h0000, 16'h0000, 0);
        send(16'h0000, 16'h0000, 0);
        send(16'h0000, 16'h0000, 0);
        wait_idle();

        // Backpressure with a second vector pushing meanwhile.
        rdy_mode = 2;
        send_basic(0, 0, 0, 0);
        fork
            begin
                send(16'h0300, 16'h0100, 0);
                send(16'hFE00, 16'h0080, 0);
                send(16'h0040, 16'h0400, 0);
                send(16'h0100, 16'hFD00, 0);
            end
            begin
                for (int t = 0; t < 50 && !out_valid; t++)
                    @(negedge clk);
                check("bp_valid_seen", 32'(out_valid), 1);
                repeat (5) @(negedge clk);
                rdy_mode = 0;
            end
        join
        wait_idle();

        // Input gaps: in_valid 1,0,0,1,0,1,1.
        send_basic(0, 2, 1, 0);
        wait_idle();

        // Reset after two of four terms.
        send(16'h0100, 16'h0100, 0);
        send(16'h0200, 16'h0100, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_sat", 32'(out_sat), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        ta.delete();
        tbv.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_basic(0, 0, 0, 0);
        wait_idle();

        // Randomized vectors with random gaps and backpressure.
        rdy_mode = 1;
        repeat (25) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                end else begin
                    ra = 16'($signed(10'($urandom)));
                    rb = 16'($signed(10'($urandom)));
                end
                send(ra, rb, int'($urandom_range(0, 2)));
            end
        end
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
